m_io_responder: RTL and testbench

- Wishbone-style I/O responder for the 0x4xxxxxxx I/O region; the slave end of the core's STB_O/WE_O/SEL_O/ACK_I initiator.
- Hosts a GPIO output register, a synchronized GPIO input register, a free-running 32-bit timer and a timer-compare register with a level interrupt.
- Answers each strobe with exactly one registered ACK_O pulse, after a programmable number of wait states.

---
 rtl/m_io_pkg.sv | 24 ++
 rtl/m_io_bytereg.sv | 36 +++
 rtl/m_io_responder.sv | 172 +++++++++++++++++
 tb/tb_m_io_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_io_pkg.sv
// Shared definitions for the I/O responder: register indices, FSM encoding
// and reset constants.
package m_io_pkg;

    localparam logic [2:0] IO_GPIO_OUT = 3'd0;
    localparam logic [2:0] IO_GPIO_IN  = 3'd1;
    localparam logic [2:0] IO_TIMER    = 3'd2;
    localparam logic [2:0] IO_TIMECMP  = 3'd3;
    localparam logic [2:0] IO_STATUS   = 3'd4;

    localparam logic [31:0] TIMECMP_RESET = 32'hffff_ffff;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } io_state_e;

    // Addresses above STATUS have no register behind them.
    function automatic logic is_unmapped(input logic [2:0] adr);
        return adr > IO_STATUS;
    endfunction

endpackage

// File: rtl/m_io_bytereg.sv
// 32-bit register with per-byte write enables; lanes not written take the
// alternative next value (hold, increment, ...) supplied by the parent.
module m_io_bytereg #(
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  lane_we,
    input  logic [31:0] wdata,
    input  logic [31:0] nxt,
    output logic [31:0] q
);

    logic [31:0] q_q;
    logic [31:0] q_d;

    always_comb begin
        q_d = nxt;
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                q_d[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/m_io_responder.sv
// Wishbone-style I/O responder: GPIO out/in, free-running timer, compare irq.
// Optional bus-error reporting on ERR_O when M_IO_RESPONDER_BUSERR_EN is defined.
module m_io_responder
    import m_io_pkg::*;
#(
    parameter int          WAITSTATES = 0,
    parameter logic [31:0] GPIO_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        RST_N_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [3:0]  SEL_I,
    input  logic [2:0]  ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    input  logic [31:0] gpio_i,
    output logic [31:0] gpio_o,
    output logic        irq_o
`ifdef M_IO_RESPONDER_BUSERR_EN
    ,
    output logic        ERR_O
`endif
);

    localparam logic [2:0] WS = 3'(WAITSTATES);

    // Handshake: STB_I is held by the initiator until it sees ACK_O (or ERR_O);
    // each accepted strobe yields exactly one single-cycle response, and a
    // strobe dropped during wait states abandons the access without effect.

    io_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] sync1_q, sync1_d;
    logic [31:0] sync2_q, sync2_d;
    logic        irq_q, irq_d;

    logic        enter_ack;
    logic        bus_err;
    logic        wr_ok;
    logic [31:0] rdata;
    logic [31:0] gpio_q, timer_q, timecmp_q;
    logic [3:0]  gpio_we, timer_we, timecmp_we;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (STB_I) begin
                    cnt_d = WS;
                    if (WS == 3'd0) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!STB_I) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef M_IO_RESPONDER_BUSERR_EN
    logic err_q, err_d;
    assign bus_err = is_unmapped(ADR_I) ||
                     (WE_I && (ADR_I == IO_GPIO_IN || ADR_I == IO_STATUS));
    assign err_d   = enter_ack && bus_err;
    assign ERR_O   = err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_comb begin
        rdata = 32'h0;
        case (ADR_I)
            IO_GPIO_OUT: rdata = gpio_q;
            IO_GPIO_IN:  rdata = sync2_q;
            IO_TIMER:    rdata = timer_q;
            IO_TIMECMP:  rdata = timecmp_q;
            IO_STATUS:   rdata = {31'h0, irq_q};
            default:     rdata = 32'h0;
        endcase
    end

    // Writes and read capture both happen on the edge that enters ACK.
    assign wr_ok      = enter_ack && WE_I && !bus_err;
    assign gpio_we    = (wr_ok && ADR_I == IO_GPIO_OUT) ? SEL_I : 4'b0000;
    assign timer_we   = (wr_ok && ADR_I == IO_TIMER)    ? SEL_I : 4'b0000;
    assign timecmp_we = (wr_ok && ADR_I == IO_TIMECMP)  ? SEL_I : 4'b0000;

    assign ack_d   = enter_ack && !bus_err;
    assign dat_d   = (enter_ack && !WE_I && !bus_err) ? rdata : 32'h0;
    assign sync1_d = gpio_i;
    assign sync2_d = sync1_q;
    assign irq_d   = timer_q >= timecmp_q;

    always_ff @(posedge clk) begin
        if (!RST_N_I) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            sync1_q <= 32'h0;
            sync2_q <= 32'h0;
            irq_q   <= 1'b0;
`ifdef M_IO_RESPONDER_BUSERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            irq_q   <= irq_d;
`ifdef M_IO_RESPONDER_BUSERR_EN
            err_q   <= err_d;
`endif
        end
    end

    m_io_bytereg #(.RESET_VAL(GPIO_RESET)) u_gpio (
        .clk     (clk),
        .rst_n   (RST_N_I),
        .lane_we (gpio_we),
        .wdata   (DAT_I),
        .nxt     (gpio_q),
        .q       (gpio_q)
    );

    m_io_bytereg #(.RESET_VAL(32'h0)) u_timer (
        .clk     (clk),
        .rst_n   (RST_N_I),
        .lane_we (timer_we),
        .wdata   (DAT_I),
        .nxt     (timer_q + 32'd1),
        .q       (timer_q)
    );

    m_io_bytereg #(.RESET_VAL(TIMECMP_RESET)) u_timecmp (
        .clk     (clk),
        .rst_n   (RST_N_I),
        .lane_we (timecmp_we),
        .wdata   (DAT_I),
        .nxt     (timecmp_q),
        .q       (timecmp_q)
    );

    assign ACK_O  = ack_q;
    assign DAT_O  = dat_q;
    assign gpio_o = gpio_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_m_io_responder.sv
// Bench for m_io_responder: one instance with no wait states, one with three;
// table vectors, directed corner sequences and a randomized model-checked run.
module tb_m_io_responder;

    localparam int          WS0 = 0;
    localparam int          WS1 = 3;
    localparam logic [31:0] GR0 = 32'h0;
    localparam logic [31:0] GR1 = 32'hDEAD_BEEF;
`ifdef M_IO_RESPONDER_BUSERR_EN
    localparam bit BUSERR = 1'b1;
`else
    localparam bit BUSERR = 1'b0;
`endif

    logic        clk;
    logic        rst_n [2];
    logic        stb   [2];
    logic        we_s  [2];
    logic [3:0]  sel   [2];
    logic [2:0]  adr   [2];
    logic [31:0] dati  [2];
    logic [31:0] dato  [2];
    logic        ack   [2];
    logic [31:0] gin   [2];
    logic [31:0] gout  [2];
    logic        irq   [2];
    logic        err   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: register contents; timer kept as value-at-edge plus edge index.
    logic [31:0] m_gpio  [2];
    logic [31:0] m_cmp   [2];
    logic [31:0] m_tbase [2];
    logic [31:0] m_gin   [2];
    int          m_tedge [2];

    m_io_responder #(.WAITSTATES(WS0), .GPIO_RESET(GR0)) u_dut0 (
        .clk(clk), .RST_N_I(rst_n[0]), .STB_I(stb[0]), .WE_I(we_s[0]),
        .SEL_I(sel[0]), .ADR_I(adr[0]), .DAT_I(dati[0]), .DAT_O(dato[0]),
        .ACK_O(ack[0]), .gpio_i(gin[0]), .gpio_o(gout[0]), .irq_o(irq[0])
`ifdef M_IO_RESPONDER_BUSERR_EN
        , .ERR_O(err[0])
`endif
    );

    m_io_responder #(.WAITSTATES(WS1), .GPIO_RESET(GR1)) u_dut1 (
        .clk(clk), .RST_N_I(rst_n[1]), .STB_I(stb[1]), .WE_I(we_s[1]),
        .SEL_I(sel[1]), .ADR_I(adr[1]), .DAT_I(dati[1]), .DAT_O(dato[1]),
        .ACK_O(ack[1]), .gpio_i(gin[1]), .gpio_o(gout[1]), .irq_o(irq[1])
`ifdef M_IO_RESPONDER_BUSERR_EN
        , .ERR_O(err[1])
`endif
    );

`ifndef M_IO_RESPONDER_BUSERR_EN
    assign err[0] = 1'b0;
    assign err[1] = 1'b0;
`endif

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Helpers
    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic logic [31:0] gr_of(input int d);
        return (d == 0) ? GR0 : GR1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    // Timer value visible just after edge e.
    function automatic logic [31:0] tval(input int d, input int e);
        return m_tbase[d] + 32'(e - m_tedge[d]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset(input int d, input int e);
        m_gpio[d]  = gr_of(d);
        m_cmp[d]   = 32'hffff_ffff;
        m_tbase[d] = 32'h0;
        m_tedge[d] = e;
    endtask

    // Driver tasks: all leave the bench 1 time unit after a rising edge.
    task automatic set_gin(input int d, input logic [31:0] v);
        gin[d]   = v;
        m_gin[d] = v;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic bus_access(input int d, input bit w, input logic [2:0] a, input logic [3:0] s,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output bit is_err, output int e);
        int  k;
        bit  got;
        stb[d] = 1'b1; we_s[d] = w; adr[d] = a; sel[d] = s; dati[d] = wd;
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (ack[d] || err[d]) got = 1'b1;
        end
        e = cyc;
        chk("response_seen", 32'(got), 32'd1);
        chk("latency", 32'(k), 32'(ws_of(d) + 1));
        chk("ack_and_err", 32'(ack[d] & err[d]), 32'd0);
        rd     = dato[d];
        is_err = err[d];
        stb[d] = 1'b0; we_s[d] = 1'b0; sel[d] = 4'h0; dati[d] = 32'h0;
        @(posedge clk); #1;
        chk("ack_single", 32'(ack[d]), 32'd0);
        chk("err_single", 32'(err[d]), 32'd0);
        chk("dat_release", dato[d], 32'h0);
    endtask

    // Scoreboard: one access checked against the model, then the model is updated.
    task automatic do_access(input int d, input bit w, input logic [2:0] a, input logic [3:0] s,
                             input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp_q[$];
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          is_err;
        int          e;
        bus_access(d, w, a, s, wd, rd, is_err, e);
        exp_err = BUSERR && (a > 3'd4 || (w && (a == 3'd1 || a == 3'd4)));
        exp_rd  = 32'h0;
        if (!w && !exp_err) begin
            case (a)
                3'd0: exp_rd = m_gpio[d];
                3'd1: exp_rd = m_gin[d];
                3'd2: exp_rd = tval(d, e - 1);
                3'd3: exp_rd = m_cmp[d];
                3'd4: exp_rd = {31'h0, tval(d, e - 2) >= m_cmp[d]};
                default: exp_rd = 32'h0;
            endcase
        end
        if (w && !exp_err) begin
            case (a)
                3'd0: m_gpio[d] = merge(m_gpio[d], wd, s);
                3'd2: begin
                    m_tbase[d] = merge(tval(d, e - 1) + 32'd1, wd, s);
                    m_tedge[d] = e;
                end
                3'd3: m_cmp[d] = merge(m_cmp[d], wd, s);
                default: ;
            endcase
        end
        exp_q.push_back(exp_rd);
        exp_q.push_back(32'(exp_err));
        exp_q.push_back(m_gpio[d]);
        exp_q.push_back(32'(tval(d, e) >= m_cmp[d]));
        chk("rdata", rd, exp_q.pop_front());
        chk("err_flag", 32'(is_err), exp_q.pop_front());
        chk("gpio_o", gout[d], exp_q.pop_front());
        chk("irq_o", 32'(irq[d]), exp_q.pop_front());
    endtask

    typedef struct {
        bit          we;
        logic [2:0]  adr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_gpio;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] rd;
        int          k;
        bit          got;

        tbl[0]  = '{1'b0, 3'd1, 4'hf, 32'h0,          32'hA5A5_0001, 32'h0000_0000};
        tbl[1]  = '{1'b1, 3'd0, 4'h4, 32'h00FF_0000,  32'h0,         32'h00FF_0000};
        tbl[2]  = '{1'b1, 3'd0, 4'h0, 32'hFFFF_FFFF,  32'h0,         32'h00FF_0000};
        tbl[3]  = '{1'b0, 3'd0, 4'hf, 32'h0,          32'h00FF_0000, 32'h00FF_0000};
        tbl[4]  = '{1'b1, 3'd0, 4'h3, 32'h1234_5678,  32'h0,         32'h00FF_5678};
        tbl[5]  = '{1'b0, 3'd0, 4'hf, 32'h0,          32'h00FF_5678, 32'h00FF_5678};
        tbl[6]  = '{1'b1, 3'd3, 4'hf, 32'h8000_0000,  32'h0,         32'h00FF_5678};
        tbl[7]  = '{1'b0, 3'd3, 4'hf, 32'h0,          32'h8000_0000, 32'h00FF_5678};
        tbl[8]  = '{1'b1, 3'd3, 4'h1, 32'hFFFF_FF55,  32'h0,         32'h00FF_5678};
        tbl[9]  = '{1'b0, 3'd3, 4'hf, 32'h0,          32'h8000_0055, 32'h00FF_5678};
        tbl[10] = '{1'b0, 3'd4, 4'hf, 32'h0,          32'h0,         32'h00FF_5678};
        tbl[11] = '{1'b0, 3'd5, 4'hf, 32'h0,          32'h0,         32'h00FF_5678};
        tbl[12] = '{1'b1, 3'd6, 4'hf, 32'hFFFF_FFFF,  32'h0,         32'h00FF_5678};
        tbl[13] = '{1'b0, 3'd7, 4'hf, 32'h0,          32'h0,         32'h00FF_5678};
        tbl[14] = '{1'b1, 3'd1, 4'hf, 32'h0BAD_0BAD,  32'h0,         32'h00FF_5678};
        tbl[15] = '{1'b0, 3'd1, 4'hf, 32'h0,          32'hA5A5_0001, 32'h00FF_5678};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; stb[d] = 1'b0; we_s[d] = 1'b0; sel[d] = 4'h0;
            adr[d] = 3'd0; dati[d] = 32'h0; gin[d] = 32'h0; m_gin[d] = 32'h0;
        end

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            model_reset(d, cyc);
            chk("rst_ack", 32'(ack[d]), 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_dat", dato[d], 32'h0);
            chk("rst_gpio", gout[d], gr_of(d));
            chk("rst_irq", 32'(irq[d]), 32'd0);
            rst_n[d] = 1'b1;
        end

        // Table vectors on the zero-wait-state instance
        set_gin(0, 32'hA5A5_0001);
        for (int i = 0; i < 16; i++) begin
            do_access(0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd, rd);
            chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_gpio", i), gout[0], tbl[i].exp_gpio);
        end

        // Timer wrap and irq fall/rise around the compare value
        do_access(0, 1'b1, 3'd3, 4'hf, 32'h0000_0002, rd);
        do_access(0, 1'b1, 3'd2, 4'hf, 32'hffff_fffe, rd);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("wrap_irq", 32'(irq[0]), 32'(tval(0, cyc - 1) >= m_cmp[0]));
        end
        do_access(0, 1'b0, 3'd2, 4'hf, 32'h0, rd);
        do_access(0, 1'b0, 3'd4, 4'hf, 32'h0, rd);
        chk("wrap_status", rd, 32'h1);

        // Three-wait-state instance: abort during WAIT has no effect
        set_gin(1, 32'h1357_9BDF);
        do_access(1, 1'b1, 3'd0, 4'hf, 32'h0102_0304, rd);
        do_access(1, 1'b1, 3'd3, 4'hf, 32'h0000_0010, rd);
        stb[1] = 1'b1; we_s[1] = 1'b1; adr[1] = 3'd0; sel[1] = 4'hf; dati[1] = 32'hCAFE_F00D;
        repeat (2) begin @(posedge clk); #1; chk("abort_early_ack", 32'(ack[1]), 32'd0); end
        stb[1] = 1'b0;
        repeat (6) begin @(posedge clk); #1; chk("abort_ack", 32'(ack[1]), 32'd0); end
        chk("abort_gpio", gout[1], 32'h0102_0304);
        do_access(1, 1'b0, 3'd0, 4'hf, 32'h0, rd);

        // Reset for one cycle during WAIT; the held strobe is then served afresh
        stb[1] = 1'b1; we_s[1] = 1'b1; adr[1] = 3'd0; sel[1] = 4'hf; dati[1] = 32'h5566_7788;
        repeat (2) begin @(posedge clk); #1; end
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        model_reset(1, cyc);
        rst_n[1] = 1'b1;
        chk("midrst_ack", 32'(ack[1]), 32'd0);
        chk("midrst_gpio", gout[1], GR1);
        chk("midrst_irq", 32'(irq[1]), 32'd0);
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (ack[1]) got = 1'b1;
        end
        chk("midrst_latency", 32'(k), 32'(WS1 + 1));
        m_gpio[1] = 32'h5566_7788;
        stb[1] = 1'b0; we_s[1] = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ack_single", 32'(ack[1]), 32'd0);
        chk("midrst_gpio_after", gout[1], 32'h5566_7788);
        do_access(1, 1'b0, 3'd2, 4'hf, 32'h0, rd);
        do_access(1, 1'b0, 3'd3, 4'hf, 32'h0, rd);
        chk("midrst_timecmp", rd, 32'hffff_ffff);

        // Randomized accesses against the model
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 50; i++) begin
                bit          w;
                logic [2:0]  a;
                logic [3:0]  s;
                logic [31:0] wd;
                if ($urandom_range(0, 7) == 0) set_gin(d, $urandom);
                w  = 1'($urandom_range(0, 1));
                a  = 3'($urandom_range(0, 7));
                s  = 4'($urandom_range(0, 15));
                wd = $urandom;
                if (a == 3'd3 && $urandom_range(0, 1) == 1) begin
                    s  = 4'hf;
                    wd = tval(d, cyc) + 32'($urandom_range(0, 40));
                end
                if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                end
                do_access(d, w, a, s, wd, rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
